// File: rtl/pin_in_capture_if.sv
// Simple request/grant register bus (naive_bus protocol) between the
// router (master) and a peripheral slave. Grants are combinational in
// the slave; read data is returned one cycle after the grant.
interface pin_in_capture_if;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/pin_in_capture.sv
// pin_in_capture: samples 32 external pins through a 2-FF synchroniser,
// debounces each bit on a slow sample tick, and exposes the stable levels
// plus sticky rise/fall flags (write-1-to-clear) on the register bus.
// Word map: 0 DATA (RO), 1 RISE (W1C), 2 FALL (W1C), 3 RAW (RO, sync2).
module pin_in_capture #(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pin_in,
  pin_in_capture_if.slave         bus
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [3:0]       CNT_LAST = 4'(STABLE_CNT - 1);

  logic [31:0]       sync1_r;
  logic [31:0]       sync2_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [31:0]       stable_r;
  logic [31:0][3:0]  cnt_r;
  logic [31:0]       rise_r;
  logic [31:0]       fall_r;
  logic [31:0]       rd_data_r;

  logic              tick_s;
  logic [31:0]       stable_nxt_s;
  logic [31:0][3:0]  cnt_nxt_s;
  logic [31:0]       rise_set_s;
  logic [31:0]       fall_set_s;
  logic [31:0]       be_mask_s;
  logic [31:0]       rise_clr_s;
  logic [31:0]       fall_clr_s;
  logic [31:0]       rd_mux_s;
  logic              unused_s;

  // Grants follow the requests but are held low while reset is asserted.
  assign bus.rd_gnt  = bus.rd_req & ~rst;
  assign bus.wr_gnt  = bus.wr_req & ~rst;
  assign bus.rd_data = rd_data_r;

  // Only addr[3:2] is decoded; the router guarantees the window.
  assign unused_s = ^{bus.rd_addr[31:4], bus.rd_addr[1:0],
                      bus.wr_addr[31:4], bus.wr_addr[1:0]};

  assign tick_s = (div_cnt_r == DIV_LAST);

  // Two-stage synchroniser for the asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 32'h0000_0000;
      sync2_r <= 32'h0000_0000;
    end else begin
      sync1_r <= pin_in;
      sync2_r <= sync1_r;
    end
  end

  // Free-running sample divider; tick is the last count before wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Per-bit debounce: count consecutive samples that differ from stable.
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = cnt_r;
    for (int i = 0; i < 32; i++) begin
      if (sync2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = 4'd0;
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]    = 4'd0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 4'd1;
      end
    end
  end

  // Debounce state only advances on a sample tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_r <= 32'h0000_0000;
      cnt_r    <= '0;
    end else if (tick_s) begin
      stable_r <= stable_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end else begin
      stable_r <= stable_r;
      cnt_r    <= cnt_r;
    end
  end

  // Edge detection on the accepted level and W1C masks from the bus.
  always_comb begin
    rise_set_s = 32'h0000_0000;
    fall_set_s = 32'h0000_0000;
    rise_clr_s = 32'h0000_0000;
    fall_clr_s = 32'h0000_0000;
    be_mask_s  = {{8{bus.wr_be[3]}}, {8{bus.wr_be[2]}},
                  {8{bus.wr_be[1]}}, {8{bus.wr_be[0]}}};
    if (tick_s) begin
      rise_set_s = stable_nxt_s & ~stable_r;
      fall_set_s = ~stable_nxt_s & stable_r;
    end else begin
      rise_set_s = 32'h0000_0000;
      fall_set_s = 32'h0000_0000;
    end
    if (bus.wr_req) begin
      case (bus.wr_addr[3:2])
        2'd1:    rise_clr_s = bus.wr_data & be_mask_s;
        2'd2:    fall_clr_s = bus.wr_data & be_mask_s;
        default: begin
          rise_clr_s = 32'h0000_0000;
          fall_clr_s = 32'h0000_0000;
        end
      endcase
    end else begin
      rise_clr_s = 32'h0000_0000;
      fall_clr_s = 32'h0000_0000;
    end
  end

  // Sticky flags: a new edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_r <= 32'h0000_0000;
      fall_r <= 32'h0000_0000;
    end else begin
      rise_r <= (rise_r & ~rise_clr_s) | rise_set_s;
      fall_r <= (fall_r & ~fall_clr_s) | fall_set_s;
    end
  end

  // Read mux sees pre-update values, so a read racing a W1C gets old data.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.rd_addr[3:2])
      2'd0:    rd_mux_s = stable_r;
      2'd1:    rd_mux_s = rise_r;
      2'd2:    rd_mux_s = fall_r;
      2'd3:    rd_mux_s = sync2_r;
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Read data is captured on a grant and held until the next granted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= 32'h0000_0000;
    end else if (bus.rd_req) begin
      rd_data_r <= rd_mux_s;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

endmodule

// File: doc/pin_in_capture.md
Name: pin_in_capture

Overview:
- naive_bus slave that samples 32 external input pins, debounces them, and exposes the stable pin levels to the RV32I core.
- Also exposes sticky rising-edge and falling-edge flags.
- Counterpart of the parallel-output LED slave: reads inputs where that block drives outputs.
- Occupies router slave slot 6, address window 0x0003_2000–0x0003_200F (mask 32'h0000_000f).

Parameters:
- SAMPLE_DIV, 50000, clk cycles between debounce samples (1 ms at 50 MHz); legal range ≥2.
- STABLE_CNT, 3, consecutive equal samples required to accept a new pin level; legal range 2..15.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset, asynchronous, active-high.
- pin_in  input  32  raw asynchronous pins.
- bus  naive_bus.slave  -  members rd_req, rd_gnt, rd_addr[31:0], rd_data[31:0], wr_req, wr_gnt, wr_addr[31:0], wr_data[31:0], wr_be[3:0].

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-high. All registers clear on rst assertion and stay cleared while rst is high.
- Reset values of bus outputs: rd_gnt=0, rd_data=0, wr_gnt=0.
- Synchroniser: pin_in passes through a 2-FF synchroniser per bit (sync1, sync2). Both reset to 0.
- Sample tick:
  - Free-running counter 0..SAMPLE_DIV-1; tick pulses one cycle when the counter equals SAMPLE_DIV-1, then the counter wraps to 0.
  - The counter resets to 0.
- Debounce, per bit, updated only on tick:
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, cnt[i] == STABLE_CNT-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - A glitch shorter than STABLE_CNT ticks never changes stable. stable resets to 0.
- Edge flags:
  - stable 0→1 sets RISE[i]; stable 1→0 sets FALL[i].
  - Flags are sticky until software clears them by writing 1 (W1C).
- Register map, word offset = addr[3:2]:
  - 0 DATA: RO, returns stable.
  - 1 RISE: W1C.
  - 2 FALL: W1C.
  - 3 RAW: RO, returns sync2; used for diagnostics.
  - Writes to DATA and RAW are accepted and ignored.
- Byte enables: a W1C write clears only the bits in bytes whose wr_be bit is 1.
- Set/clear collision: if an edge sets bit i in the same cycle a W1C write clears bit i, set wins and the flag remains 1.
- Read handshake:
  - rd_gnt = rd_req, combinational; a read is granted in the same cycle it is requested.
  - rd_data is registered and valid the cycle after grant.
  - rd_data holds its value until the next granted read.
  - Back-to-back reads on consecutive cycles are supported at one per cycle.
- Write handshake:
  - wr_gnt = wr_req, combinational.
  - The write takes effect at the clk edge ending the grant cycle.
- Read/write ordering: a read of RISE/FALL in the same cycle as a W1C to that register returns the pre-clear value.
- Address decode: only addr[3:2] is decoded; addr[1:0] is ignored. The router guarantees the request lies in the window.
- Reset mid-operation: reset clears all state and drops the grants. An in-flight read returns 0 after reset release. No pending transaction survives reset.
- Size: 32×4-bit counters plus the register file, about 200 lines of RTL.

Test Plan:
- Reset: with rst=1, pin_in=32'hFFFF_FFFF → rd_data=0, DATA=0, RISE=0, FALL=0. Release rst, read DATA before 3 ticks have elapsed → DATA=0.
- Debounce (SAMPLE_DIV=4, STABLE_CNT=3):
  - pin_in[0] steps 0→1 and holds → DATA[0]=1 no earlier than 2 sync cycles + 3 ticks; RISE=32'h1 at the same time.
  - Read at offset 0x4 → rd_data=32'h0000_0001 one cycle after rd_gnt.
- Glitch: pin_in[5] high for 2 ticks then low → DATA=0, RISE=0, FALL=0. RAW[5] is observed high during the pulse.
- W1C with byte enables:
  - With RISE=32'h0101_0101, write 0x4 data=32'hFFFF_FFFF, wr_be=4'b0011 → RISE=32'h0101_0000.
  - Then write wr_be=4'b1111 → RISE=0.
- Collision: a tick causes a rise on bit 3 in the same cycle as W1C data=32'h8 to RISE → RISE[3]=1 afterwards.
- Bus throughput and mid-read reset:
  - Back-to-back reads of offsets 0,1,2,3 on 4 consecutive cycles → 4 grants, each rd_data correct one cycle later.
  - Assert rst between the grant and the data cycle → rd_data=0.
